keypad_matrix_scanner: RTL



---
 rtl/keypad_matrix_scanner.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : keypad_matrix_scanner                                      |
// | Description : Row-scanned ROWS x COLS key matrix reader. Rows are driven |
// |               active-low one at a time, and columns are sampled          |
// |               active-low. Each key is debounced over whole scan frames.  |
// |               The block keeps a debounced pressed-key bitmap and emits   |
// |               one press/release event per changed key over valid/ready.  |
// | Ports       : clk       - system clock                                   |
// |               RSTn      - asynchronous active-low reset                  |
// |               col       - column sense lines, 0 = pressed on driven row  |
// |               row       - row drive, exactly one bit low                 |
// |               key_state - debounced bitmap, bit r*COLS+c                 |
// |               any_key   - OR of key_state                                |
// |               ev_valid  - event available                                |
// |               ev_ready  - consumer accepts event                         |
// |               ev_code   - key index r*COLS+c of the event                |
// |               ev_press  - 1 = press, 0 = release                         |
// | Revision    : 1.0 - initial parametrised release                         |
// +--------------------------------------------------------------------------+
module keypad_matrix_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int CLK_DIV  = 2500,
  parameter int DEBOUNCE = 3,
  localparam int KW      = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic [COLS-1:0]      col,
  output logic [ROWS-1:0]      row,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 any_key,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [KW-1:0]        ev_code,
  output logic                 ev_press
);

  localparam int c_NKEYS = ROWS * COLS;
  localparam int c_DIV_W = $clog2(CLK_DIV);
  localparam int c_ROW_W = $clog2(ROWS);
  localparam int c_CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(ROWS - 1);
  localparam logic [c_CNT_W-1:0] c_DEB      = c_CNT_W'(DEBOUNCE);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  // Scan state
  logic [c_DIV_W-1:0] r_div;
  logic [c_ROW_W-1:0] r_row_idx;
  logic [ROWS-1:0]    r_row;
  logic [c_NKEYS-1:0] r_raw;
  logic [c_NKEYS-1:0] r_prev;
  logic [c_CNT_W-1:0] r_stable;

  // Debounced state and emit datapath
  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic [c_NKEYS-1:0] r_key_state;
  logic [c_NKEYS-1:0] r_diff;
  logic               r_loaded;
  logic [KW-1:0]      r_code;
  logic               r_press;

  logic               w_capture;
  logic               w_frame_end;
  logic [c_NKEYS-1:0] w_raw_new;
  logic [c_CNT_W-1:0] w_stable_next;
  logic               w_commit;
  logic               w_handshake;
  logic [KW-1:0]      w_low_idx;
  logic [c_NKEYS-1:0] w_clr_mask;

  assign w_capture   = (r_div == c_DIV_LAST);
  assign w_frame_end = w_capture && (r_row_idx == c_ROW_LAST);

  // Raw frame including the row being captured this cycle; at frame end this
  // is the complete new frame. col is assumed to arrive already synchronised.
  always_comb begin
    w_raw_new = r_raw;
    for (int r = 0; r < ROWS; r++) begin
      if (r_row_idx == c_ROW_W'(r)) begin
        w_raw_new[r*COLS +: COLS] = ~col;
      end
    end
  end

  always_comb begin
    if (w_raw_new == r_prev) begin
      w_stable_next = (r_stable == c_DEB) ? c_DEB : r_stable + 1'b1;
    end else begin
      w_stable_next = c_CNT_W'(1);
    end
  end

  // A stable change waits in the raw frame while an emit is in progress and
  // is picked up at the first frame end after the FSM is idle again.
  assign w_commit = w_frame_end && (w_stable_next == c_DEB) &&
                    (w_raw_new != r_key_state) && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_div     <= '0;
      r_row_idx <= '0;
      r_row     <= {{(ROWS-1){1'b1}}, 1'b0};
      r_raw     <= '0;
      r_prev    <= '0;
      r_stable  <= '0;
    end else begin
      if (w_capture) begin
        r_div     <= '0;
        r_raw     <= w_raw_new;
        r_row     <= {r_row[ROWS-2:0], r_row[ROWS-1]};
        r_row_idx <= (r_row_idx == c_ROW_LAST) ? '0 : r_row_idx + 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_frame_end) begin
        r_prev   <= w_raw_new;
        r_stable <= w_stable_next;
      end
    end
  end

  // Lowest set bit of diff: descending scan leaves the smallest index.
  always_comb begin
    w_low_idx = '0;
    for (int i = c_NKEYS - 1; i >= 0; i--) begin
      if (r_diff[i]) begin
        w_low_idx = KW'(i);
      end
    end
  end

  always_comb begin
    w_clr_mask         = '0;
    w_clr_mask[r_code] = 1'b1;
  end

  assign w_handshake = ev_valid && ev_ready;

  // Emit FSM: state register
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Emit FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_commit) w_state_next = S_EMIT;
      S_EMIT: if (w_handshake && ((r_diff & ~w_clr_mask) == '0)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Emit FSM: outputs
  always_comb begin
    ev_valid = (r_state == S_EMIT) && r_loaded;
    ev_code  = r_code;
    ev_press = r_press;
  end

  // Event datapath. Each event spends one cycle being loaded from diff
  // into the output registers, then is held until it is accepted. The
  // output registers stay fixed under backpressure.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_key_state <= '0;
      r_diff      <= '0;
      r_loaded    <= 1'b0;
      r_code      <= '0;
      r_press     <= 1'b0;
    end else if (w_commit) begin
      r_key_state <= w_raw_new;
      r_diff      <= w_raw_new ^ r_key_state;
      r_loaded    <= 1'b0;
    end else if (r_state == S_EMIT) begin
      if (!r_loaded) begin
        r_code   <= w_low_idx;
        r_press  <= r_key_state[w_low_idx];
        r_loaded <= 1'b1;
      end else if (ev_ready) begin
        r_diff   <= r_diff & ~w_clr_mask;
        r_loaded <= 1'b0;
      end
    end
  end

  assign row       = r_row;
  assign key_state = r_key_state;
  assign any_key   = |r_key_state;

endmodule
`default_nettype wire
